// File: rtl/draw_player_anim_if.sv
// Movement command type and the VGA timing/colour bundle shared by the sprite overlay blocks.
// Timing fields travel with rgb so every stage can delay them as a single unit.
package state_pkg;
  typedef enum logic [2:0] {IDLE, RIGHT1, LEFT1, RIGHT2, LEFT2} State;
endpackage

interface vga_if;
  logic [11:0] vcount;
  logic        vsync;
  logic        vblnk;
  logic [11:0] hcount;
  logic        hsync;
  logic        hblnk;
  logic [11:0] rgb;

  modport in  (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
  modport out (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
endinterface

// File: rtl/draw_player_anim.sv
// Overlays an animated walking player sprite on the VGA stream.
// Latency 2 clk for all fields; no backpressure, one pixel accepted and emitted per clk.
module draw_player_anim
  import state_pkg::*;
#(
  parameter int          PLAYER_W        = 40,
  parameter int          PLAYER_H        = 80,
  parameter int          LEG_H           = 20,
  parameter int          LEG_LIFT        = 8,
  parameter int          FRAMES_PER_STEP = 8,
  parameter logic [11:0] COLOR_BODY      = 12'hF0F,
  parameter logic [11:0] COLOR_EYE       = 12'h0FF
) (
  input  logic        clk,
  input  logic        rst,
  vga_if.in           vga_in,
  vga_if.out          vga_out,
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  input  State        state,
  input  logic        enable
);

  localparam int BODY_H = PLAYER_H - LEG_H;
  localparam int CNT_W  = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAMES_PER_STEP - 1);

  typedef enum logic       {FACE_RIGHT, FACE_LEFT} facing_e;
  typedef enum logic [1:0] {STAND, STEP_A, STEP_B} anim_e;
  typedef enum logic [1:0] {PIX_BG, PIX_BODY, PIX_EYE} pix_e;

  typedef struct packed {
    logic [11:0] vcount;
    logic        vsync;
    logic        vblnk;
    logic [11:0] hcount;
    logic        hsync;
    logic        hblnk;
    logic [11:0] rgb;
  } vga_t;

  vga_t             s1_d, s1_q, s2_d, s2_q;
  pix_e             pix_d, pix_q;
  logic [11:0]      x_sh_d, x_sh_q, y_sh_d, y_sh_q;
  State             st_sh_d, st_sh_q;
  logic             en_sh_d, en_sh_q;
  facing_e          facing_d, facing_q;
  anim_e            anim_d, anim_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  logic        frame_start;
  logic [12:0] rx, ry;
  logic        in_sprite, lifted;
  logic [11:0] eye_x0;

  assign frame_start = (vga_in.vcount == 12'd0) && (vga_in.hcount == 12'd0);

  // The walk FSM steps on the command that was in force during the frame just ended.
  always_comb begin
    x_sh_d   = x_sh_q;
    y_sh_d   = y_sh_q;
    st_sh_d  = st_sh_q;
    en_sh_d  = en_sh_q;
    facing_d = facing_q;
    anim_d   = anim_q;
    cnt_d    = cnt_q;
    if (frame_start) begin
      x_sh_d  = xpos;
      y_sh_d  = ypos;
      st_sh_d = state;
      en_sh_d = enable;
      case (st_sh_q)
        RIGHT1, RIGHT2: facing_d = FACE_RIGHT;
        LEFT1, LEFT2:   facing_d = FACE_LEFT;
        default:        facing_d = facing_q;
      endcase
      if (st_sh_q == IDLE) begin
        anim_d = STAND;
        cnt_d  = '0;
      end else if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        case (anim_q)
          STAND:   anim_d = STEP_A;
          STEP_A:  anim_d = STEP_B;
          default: anim_d = STEP_A;
        endcase
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Using the _d shadows lets the frame-start pixel already see this frame's values.
  // A 13-bit difference keeps sprites near 4095 from aliasing onto the left/top edge.
  always_comb begin
    rx        = {1'b0, vga_in.hcount} - {1'b0, x_sh_d};
    ry        = {1'b0, vga_in.vcount} - {1'b0, y_sh_d};
    in_sprite = !rx[12] && !ry[12] &&
                (rx[11:0] < 12'(PLAYER_W)) && (ry[11:0] < 12'(PLAYER_H));
    lifted    = ry[11:0] >= 12'(PLAYER_H - LEG_LIFT);
    eye_x0    = (facing_d == FACE_RIGHT) ? 12'(PLAYER_W - 10) : 12'd5;
    pix_d     = PIX_BG;
    if (en_sh_d && !vga_in.hblnk && !vga_in.vblnk && in_sprite) begin
      if (ry[11:0] < 12'(BODY_H)) begin
        if ((ry[11:0] >= 12'd5) && (ry[11:0] <= 12'd9) &&
            (rx[11:0] >= eye_x0) && (rx[11:0] < eye_x0 + 12'd5))
          pix_d = PIX_EYE;
        else
          pix_d = PIX_BODY;
      end else if (rx[11:0] < 12'(PLAYER_W * 3 / 8)) begin
        if (!(anim_d == STEP_A && lifted)) pix_d = PIX_BODY;
      end else if (rx[11:0] >= 12'(PLAYER_W * 5 / 8)) begin
        if (!(anim_d == STEP_B && lifted)) pix_d = PIX_BODY;
      end
    end
  end

  always_comb begin
    s1_d.vcount = vga_in.vcount;
    s1_d.vsync  = vga_in.vsync;
    s1_d.vblnk  = vga_in.vblnk;
    s1_d.hcount = vga_in.hcount;
    s1_d.hsync  = vga_in.hsync;
    s1_d.hblnk  = vga_in.hblnk;
    s1_d.rgb    = vga_in.rgb;
    s2_d        = s1_q;
    case (pix_q)
      PIX_BODY: s2_d.rgb = COLOR_BODY;
      PIX_EYE:  s2_d.rgb = COLOR_EYE;
      default:  s2_d.rgb = s1_q.rgb;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q     <= '0;
      s2_q     <= '0;
      pix_q    <= PIX_BG;
      x_sh_q   <= '0;
      y_sh_q   <= '0;
      st_sh_q  <= IDLE;
      en_sh_q  <= 1'b0;
      facing_q <= FACE_RIGHT;
      anim_q   <= STAND;
      cnt_q    <= '0;
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      pix_q    <= pix_d;
      x_sh_q   <= x_sh_d;
      y_sh_q   <= y_sh_d;
      st_sh_q  <= st_sh_d;
      en_sh_q  <= en_sh_d;
      facing_q <= facing_d;
      anim_q   <= anim_d;
      cnt_q    <= cnt_d;
    end
  end

  assign vga_out.vcount = s2_q.vcount;
  assign vga_out.vsync  = s2_q.vsync;
  assign vga_out.vblnk  = s2_q.vblnk;
  assign vga_out.hcount = s2_q.hcount;
  assign vga_out.hsync  = s2_q.hsync;
  assign vga_out.hblnk  = s2_q.hblnk;
  assign vga_out.rgb    = s2_q.rgb;

endmodule
